// File: rtl/i2c_slave_pkg.sv
// ---------------------------------------------------------------------------
// i2c_slave_pkg
// Shared definitions for the I2C-slave AXI write path.
//   WORD_BYTES : number of byte lanes in one packed word
//   state_e    : packer FSM states (IDLE, ADDR, DATA, FLUSH, DRAIN)
//   mapLane    : logical lane counter + endianness select -> physical lane
// ---------------------------------------------------------------------------
package i2c_slave_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Byte k of a word lands in lane k, or in lane 3-k when the little_end
   // select is set.
   function automatic logic [1:0] mapLane(input logic [1:0] lane, input logic littleEnd);
      return littleEnd ? (2'd3 - lane) : lane;
   endfunction

endpackage

// File: rtl/i2c_slave_word_reg.sv
// ---------------------------------------------------------------------------
// i2c_slave_word_reg
// Single-entry valid/ready output register holding one packed word.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture data/strb/addr (only issued while the entry is empty)
//   data_i/strb_i/addr_i : word contents to capture
//   valid_o      : entry occupied
//   ready_i      : consumer accepts the word; frees the entry
//   data_o/strb_o/addr_o : held word contents
// ---------------------------------------------------------------------------
module i2c_slave_word_reg #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [31:0]           data_i,
   input  logic [3:0]            strb_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [31:0]           data_o,
   output logic [3:0]            strb_o,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic                  valid_q;
   logic [31:0]           data_q;
   logic [3:0]            strb_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   // The entry fills on load and empties on a completed handshake. The
   // packer never loads while the entry is occupied, so load simply wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
         addr_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         strb_q  <= strb_i;
         addr_q  <= addr_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign strb_o  = strb_q;
   assign addr_o  = addr_q;

endmodule

// File: rtl/i2c_slave_wr_packer.sv
// ---------------------------------------------------------------------------
// i2c_slave_wr_packer
// Packs the I2C slave byte stream into 32-bit words for the AXI write FSM.
// The first ADDR_BYTES bytes after a start form a byte offset (MSB first);
// the remaining bytes are packed into lanes with per-lane strobes.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   start_i, stop_i      : 1-cycle START / STOP pulses from the byte engine
//   byte_valid_i, byte_i : received byte
//   byte_ready_o         : byte accepted; low stretches SCL
//   little_end_i         : lane mapping select
//   word_valid_o/word_ready_i/word_data_o/word_strb_o/word_addr_o : word out
//   done_o               : end-of-transfer pulse once every word is accepted
//   busy_o               : FSM not idle
//   ovf_o                : sticky, byte offered while not ready
// ---------------------------------------------------------------------------
module i2c_slave_wr_packer #(
   parameter int ADDR_BYTES = 2,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_i,
   output logic                  byte_ready_o,
   input  logic                  little_end_i,
   output logic                  word_valid_o,
   input  logic                  word_ready_i,
   output logic [31:0]           word_data_o,
   output logic [3:0]            word_strb_o,
   output logic [ADDR_WIDTH-1:0] word_addr_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic                  ovf_o
);

   import i2c_slave_pkg::*;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] offset_q, offset_d;
   logic [2:0]            addrCnt_q, addrCnt_d;
   logic [1:0]            lane_q, lane_d;
   logic [31:0]           accData_q, accData_d;
   logic [3:0]            accStrb_q, accStrb_d;
   logic                  ovf_q, ovf_d;
   logic                  startPend_q, startPend_d;

   logic                  wordValid;
   logic                  loadWord;
   logic                  byteReady;
   logic                  byteTake;
   logic                  doneNow;
   logic [1:0]            physLane;
   logic [31:0]           mergedData;
   logic [3:0]            mergedStrb;

   // Bytes are refused while a flush or drain is in progress, and while the
   // output entry is still full and this byte would finish a word (either
   // the last lane or a byte arriving together with start/stop).
   always_comb begin
      byteReady = 1'b1;
      if (rst_i) begin
         byteReady = 1'b0;
      end else if (state_q == ST_FLUSH || state_q == ST_DRAIN) begin
         byteReady = 1'b0;
      end else if (state_q == ST_DATA && wordValid &&
                   (lane_q == 2'(WORD_BYTES - 1) || stop_i || start_i)) begin
         byteReady = 1'b0;
      end
   end

   assign byteTake = byte_valid_i && byteReady;

   // Accumulator contents with the current byte folded in. This is what a
   // completed or flushed word carries, so a byte arriving with stop/start
   // still ends up in the flushed word.
   always_comb begin
      physLane   = mapLane(lane_q, little_end_i);
      mergedData = accData_q;
      mergedStrb = accStrb_q;
      if (state_q == ST_DATA && byteTake) begin
         mergedData[{physLane, 3'b000} +: 8] = byte_i;
         mergedStrb[physLane]                = 1'b1;
      end
   end

   // Main sequencing: offset collection, lane packing, flushing partial
   // words on start/stop, and waiting for the output entry to drain before
   // signalling done. A start seen during FLUSH or DRAIN is remembered and
   // sends the FSM back to ADDR on exit. The offset is cleared whenever a
   // new address phase begins so stale high bits never leak into it.
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      addrCnt_d   = addrCnt_q;
      lane_d      = lane_q;
      accData_d   = accData_q;
      accStrb_d   = accStrb_q;
      startPend_d = startPend_q;
      loadWord    = 1'b0;
      doneNow     = 1'b0;
      ovf_d       = ovf_q | (byte_valid_i & ~byteReady);
      if (start_i) begin
         ovf_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d   = ST_ADDR;
               addrCnt_d = '0;
               offset_d  = '0;
            end
         end

         ST_ADDR: begin
            if (start_i) begin
               addrCnt_d = '0;
               offset_d  = '0;
            end else if (stop_i) begin
               state_d = ST_IDLE;
            end else if (byteTake) begin
               offset_d  = (offset_q << 8) | ADDR_WIDTH'(byte_i);
               addrCnt_d = addrCnt_q + 3'd1;
               if (addrCnt_q == 3'(ADDR_BYTES - 1)) begin
                  state_d   = ST_DATA;
                  lane_d    = offset_d[1:0];
                  accData_d = '0;
                  accStrb_d = '0;
               end
            end
         end

         ST_DATA: begin
            if (start_i || stop_i) begin
               if (mergedStrb != 4'd0 && wordValid) begin
                  state_d     = ST_FLUSH;
                  accData_d   = mergedData;
                  accStrb_d   = mergedStrb;
                  startPend_d = start_i;
               end else begin
                  loadWord  = (mergedStrb != 4'd0);
                  accData_d = '0;
                  accStrb_d = '0;
                  if (start_i) begin
                     state_d   = ST_ADDR;
                     addrCnt_d = '0;
                     offset_d  = '0;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end
            end else if (byteTake) begin
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'(WORD_BYTES - 1)) begin
                  loadWord  = 1'b1;
                  accData_d = '0;
                  accStrb_d = '0;
                  offset_d  = offset_q + ADDR_WIDTH'(WORD_BYTES);
               end else begin
                  accData_d = mergedData;
                  accStrb_d = mergedStrb;
               end
            end
         end

         ST_FLUSH: begin
            if (start_i) begin
               startPend_d = 1'b1;
            end
            if (!wordValid) begin
               loadWord    = 1'b1;
               accData_d   = '0;
               accStrb_d   = '0;
               startPend_d = 1'b0;
               if (startPend_q || start_i) begin
                  state_d   = ST_ADDR;
                  addrCnt_d = '0;
                  offset_d  = '0;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            if (start_i) begin
               startPend_d = 1'b1;
            end
            if (!wordValid) begin
               doneNow     = 1'b1;
               startPend_d = 1'b0;
               if (startPend_q || start_i) begin
                  state_d   = ST_ADDR;
                  addrCnt_d = '0;
                  offset_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and accumulator registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         offset_q    <= '0;
         addrCnt_q   <= '0;
         lane_q      <= '0;
         accData_q   <= '0;
         accStrb_q   <= '0;
         ovf_q       <= 1'b0;
         startPend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         addrCnt_q   <= addrCnt_d;
         lane_q      <= lane_d;
         accData_q   <= accData_d;
         accStrb_q   <= accStrb_d;
         ovf_q       <= ovf_d;
         startPend_q <= startPend_d;
      end
   end

   i2c_slave_word_reg #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) wordReg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (loadWord),
      .data_i  (mergedData),
      .strb_i  (mergedStrb),
      .addr_i  ({offset_q[ADDR_WIDTH-1:2], 2'b00}),
      .valid_o (wordValid),
      .ready_i (word_ready_i),
      .data_o  (word_data_o),
      .strb_o  (word_strb_o),
      .addr_o  (word_addr_o)
   );

   assign word_valid_o = wordValid;
   assign byte_ready_o = byteReady;
   assign done_o       = doneNow & ~rst_i;
   assign busy_o       = (state_q != ST_IDLE);
   assign ovf_o        = ovf_q;

endmodule
